// File: rtl/safe_softmax_pkg.sv
// Shared types and helpers for the safe-softmax row sequencer.
//   state_e     : row FSM states (IDLE -> LOAD -> EXP -> DONE -> IDLE)
//   E_ONE       : exp-unit output for a zero input at the default 16-bit width
//   len_width() : width of a length field able to hold 0..max_len
//   sum_width() : width of an accumulator summing max_len d_w-bit values without overflow
package safe_softmax_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EXP, DONE} state_e;

  localparam int unsigned EXP_D_W = 16;
  localparam logic [EXP_D_W-1:0] E_ONE = 16'h8000;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned sum_width(input int unsigned d_w, input int unsigned max_len);
    return d_w + $clog2(max_len);
  endfunction

endpackage

// File: rtl/safe_softmax_exp.sv
// Combinational exp unit for non-positive arguments.
//   i_d : D_W-bit two's-complement argument, always <= 0, fixed point with 8 fraction bits
//   o_e : unsigned result, 1.0 == 2^(D_W-1)
// Computes 2^(i_d/256); scores are pre-scaled by log2(e) upstream. The integer part of
// the magnitude is a right shift, the fraction a linear approximation of 2^-f.
module safe_softmax_exp #(
  parameter int unsigned D_W = 16
) (
  input  logic [D_W-1:0] i_d,
  output logic [D_W-1:0] o_e
);

  localparam int unsigned SH_W = D_W - 7;

  logic [D_W:0]    mag;
  logic [SH_W-1:0] shift;
  logic [7:0]      frac;
  logic [D_W-1:0]  mant;

  always_comb begin
    mag   = '0 - {i_d[D_W-1], i_d};
    shift = mag[D_W:8];
    frac  = mag[7:0];
    mant  = {1'b1, {(D_W-1){1'b0}}} - ({{(D_W-8){1'b0}}, frac} << (D_W - 10));
    // Anything shifted by D_W or more underflows to zero, including the saturated minimum.
    o_e   = (shift >= SH_W'(D_W)) ? '0 : (mant >> shift);
  end

endmodule

// File: rtl/safe_softmax_row_ctrl.sv
// Row sequencer for safe softmax.
//   Pass 1 (LOAD): accepts I_LEN signed scores on I_X/I_X_VALID/O_X_READY into a local
//   buffer while tracking the row maximum (O_MAX).
//   Pass 2 (EXP): replays the buffer, streams exp(x - max) on O_E/O_E_VALID/I_E_READY with
//   O_E_LAST on the final beat, and accumulates the sum, reported as a one-cycle O_SUM_VALID
//   pulse in DONE. O_BUSY covers the whole row. I_RST is synchronous, active-high.
module safe_softmax_row_ctrl
  import safe_softmax_pkg::*;
#(
  parameter int unsigned D_W     = 16,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = len_width(MAX_LEN),
  parameter int unsigned SUM_W   = sum_width(D_W, MAX_LEN)
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_START,
  input  logic [LEN_W-1:0] I_LEN,
  output logic             O_BUSY,
  input  logic             I_X_VALID,
  output logic             O_X_READY,
  input  logic [D_W-1:0]   I_X,
  output logic             O_E_VALID,
  input  logic             I_E_READY,
  output logic [D_W-1:0]   O_E,
  output logic             O_E_LAST,
  output logic [D_W-1:0]   O_MAX,
  output logic             O_SUM_VALID,
  output logic [SUM_W-1:0] O_SUM
);

  localparam int unsigned PTR_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [D_W-1:0]   max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             busy_q, busy_d;
  logic             x_ready_q, x_ready_d;
  logic             e_valid_q, e_valid_d;
  logic [D_W-1:0]   e_q, e_d;
  logic             e_last_q, e_last_d;
  logic             sum_valid_q, sum_valid_d;
  logic [SUM_W-1:0] sum_out_q, sum_out_d;

  logic [D_W-1:0]   mem [MAX_LEN];
  logic             x_hs, e_hs, e_load;
  logic [D_W-1:0]   rd_data, d_sat, e_raw;
  logic [D_W:0]     diff;

  assign x_hs    = I_X_VALID & x_ready_q;
  assign e_hs    = e_valid_q & I_E_READY;
  assign e_load  = (state_q == EXP) && (!e_valid_q || I_E_READY) && (rd_ptr_q < len_q);
  assign rd_data = mem[rd_ptr_q[PTR_W-1:0]];
  assign diff    = {rd_data[D_W-1], rd_data} - {max_q[D_W-1], max_q};
  // diff <= 0 always; clamp anything below the D_W-bit range rather than letting it wrap.
  assign d_sat   = (diff[D_W] && !diff[D_W-1]) ? {1'b1, {(D_W-1){1'b0}}} : diff[D_W-1:0];

  safe_softmax_exp #(
    .D_W (D_W)
  ) u_exp (
    .i_d (d_sat),
    .o_e (e_raw)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    max_d       = max_q;
    sum_d       = sum_q;
    busy_d      = busy_q;
    x_ready_d   = x_ready_q;
    e_valid_d   = e_valid_q;
    e_d         = e_q;
    e_last_d    = e_last_q;
    sum_valid_d = sum_valid_q;
    sum_out_d   = sum_out_q;
    unique case (state_q)
      IDLE: begin
        if (I_START && (I_LEN != '0)) begin
          len_d     = (I_LEN > LEN_MAX) ? LEN_MAX : I_LEN;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          sum_d     = '0;
          busy_d    = 1'b1;
          x_ready_d = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (x_hs) begin
          wr_ptr_d = wr_ptr_q + LEN_ONE;
          if ((wr_ptr_q == '0) || ($signed(I_X) > $signed(max_q))) begin
            max_d = I_X;
          end
          if (wr_ptr_q == len_q - LEN_ONE) begin
            x_ready_d = 1'b0;
            state_d   = EXP;
          end
        end
      end
      EXP: begin
        if (e_load) begin
          e_d       = e_raw;
          e_valid_d = 1'b1;
          e_last_d  = (rd_ptr_q == len_q - LEN_ONE);
          sum_d     = sum_q + SUM_W'(e_raw);
          rd_ptr_d  = rd_ptr_q + LEN_ONE;
        end else if (e_hs) begin
          // Only the last beat can be consumed without a refill behind it.
          e_valid_d = 1'b0;
          if (e_last_q) begin
            e_last_d    = 1'b0;
            sum_valid_d = 1'b1;
            sum_out_d   = sum_q;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        sum_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      busy_q      <= 1'b0;
      x_ready_q   <= 1'b0;
      e_valid_q   <= 1'b0;
      e_q         <= '0;
      e_last_q    <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      busy_q      <= busy_d;
      x_ready_q   <= x_ready_d;
      e_valid_q   <= e_valid_d;
      e_q         <= e_d;
      e_last_q    <= e_last_d;
      sum_valid_q <= sum_valid_d;
      sum_out_q   <= sum_out_d;
    end
  end

  // Buffer contents need no reset; entries are always written before they are read.
  always_ff @(posedge I_CLK) begin
    if (x_hs) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= I_X;
    end
  end

  assign O_BUSY      = busy_q;
  assign O_X_READY   = x_ready_q;
  assign O_E_VALID   = e_valid_q;
  assign O_E         = e_q;
  assign O_E_LAST    = e_last_q;
  assign O_MAX       = max_q;
  assign O_SUM_VALID = sum_valid_q;
  assign O_SUM       = sum_out_q;

endmodule

// File: doc/safe_softmax_row_ctrl.md
Name: safe_softmax_row_ctrl

Overview:
- Row-level sequencer for the safe-softmax exp datapath in the attention block.
- Pass 1 streams one row of D_W-bit signed scores into a local buffer and tracks the running row maximum.
- Pass 2 replays the buffer, feeds (x - max) to one shared combinational exp unit, streams the exp values out, and accumulates their sum for the normaliser downstream.

Parameters:
- D_W, 16, score and exp data width (signed score, unsigned exp).
- MAX_LEN, 64, maximum row length and buffer depth.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- SUM_W, D_W+$clog2(MAX_LEN), width of the exp-sum accumulator; it cannot overflow.

Ports:
- I_CLK  in  1  clock.
- I_RST  in  1  synchronous, active-high reset.
- I_START  in  1  one-cycle pulse; starts a row when the block is idle.
- I_LEN  in  LEN_W  row length; sampled on an accepted I_START.
- O_BUSY  out  1  high from an accepted start until the end of DONE.
- I_X_VALID  in  1  score-in valid.
- O_X_READY  out  1  score-in ready.
- I_X  in  D_W  signed score.
- O_E_VALID  out  1  exp-out valid.
- I_E_READY  in  1  exp-out ready.
- O_E  out  D_W  exp(x - max), registered.
- O_E_LAST  out  1  marks the last exp of the row; qualified by O_E_VALID.
- O_MAX  out  D_W  row maximum; stable from the end of LOAD until the next accepted start.
- O_SUM_VALID  out  1  one-cycle pulse; O_SUM is valid in that cycle.
- O_SUM  out  SUM_W  sum of all O_E values of the row.

Behaviour:
- Reset (synchronous, I_RST=1 at a clock edge):
  - state goes to IDLE;
  - all outputs go to 0 (O_BUSY, O_X_READY, O_E_VALID, O_E, O_E_LAST, O_MAX, O_SUM_VALID, O_SUM);
  - pointers and accumulator are cleared; buffer contents are don't-care.
  - A reset mid-row discards the row; no partial O_SUM is ever emitted.
- FSM states: IDLE -> LOAD -> EXP -> DONE -> IDLE.
- IDLE:
  - I_START with I_LEN != 0 latches len = min(I_LEN, MAX_LEN), clears wr_ptr, rd_ptr and sum, and moves to LOAD.
  - I_START with I_LEN == 0 is ignored.
  - I_START in any other state is ignored.
- LOAD:
  - O_X_READY = 1.
  - Each handshake (I_X_VALID & O_X_READY) writes buf[wr_ptr] = I_X and increments wr_ptr.
  - The first element loads max directly; later elements update max = signed max(max, I_X).
  - When the handshake with wr_ptr == len-1 occurs, the next state is EXP; O_X_READY is 0 from that next cycle.
- EXP:
  - The output register loads when (!O_E_VALID || I_E_READY) and rd_ptr < len. On load:
    - d = {x[D_W-1],x} - {max[D_W-1],max}, computed in D_W+1 bits; d is always <= 0;
    - d is saturated to -2^(D_W-1) and applied to the exp unit;
    - O_E gets the exp result, O_E_VALID = 1, and O_E_LAST = (rd_ptr == len-1);
    - sum += zero-extended exp result, and rd_ptr increments.
  - The first O_E_VALID rises 2 cycles after the last LOAD handshake.
  - With I_E_READY held at 1, the block sustains one exp per cycle.
  - O_E, O_E_VALID and O_E_LAST hold stable while O_E_VALID=1 and I_E_READY=0.
  - A handshake with O_E_LAST=1 clears O_E_VALID and moves to DONE.
- DONE:
  - O_SUM_VALID = 1 for exactly one cycle, with O_SUM equal to the final sum.
  - O_MAX is held.
  - Next state is IDLE and O_BUSY falls.
  - O_SUM keeps its value until the next accepted start.
- Boundaries:
  - len == 1: a single O_E with O_E_LAST=1, equal to exp(0).
  - len > MAX_LEN: clamped to MAX_LEN; extra input beats are never accepted.
  - Simultaneous I_START and DONE: I_START is ignored because the block is not yet IDLE.
  - The most negative score against a positive max saturates d and gives the smallest exp value, never a wrap.

Decomposition:
- A shared package safe_softmax_pkg holds:
  - the state enum typedef {IDLE, LOAD, EXP, DONE};
  - localparam E_ONE = exp-unit output for input 0 (reused by benches);
  - the width helper functions.
- The exp math is the existing combinational safe_softmax_exp, instantiated once as u_exp.
- The buffer, max, pointers and FSM stay inline; no further sub-modules.

Test Plan:
- Reset mid-row: reset after 3 of 8 LOAD beats -> all outputs 0 and state IDLE; a restart with len=2 then completes normally.
- Equal row: len=4, I_X=16'h0100 x4, I_E_READY=1:
  - O_MAX=16'h0100;
  - four O_E=E_ONE on consecutive cycles, O_E_LAST on the 4th;
  - O_SUM=4*E_ONE.
- Mixed signs: len=3, I_X = 16'hFF00, 16'h0200, 16'h0000:
  - O_MAX=16'h0200;
  - the second O_E equals E_ONE, the other two are each < E_ONE;
  - O_SUM equals the sum of the three O_E values observed.
- Back-pressure: len=5, I_E_READY toggled 1/0 every cycle -> O_E is held stable while stalled, no beat is lost or duplicated, and O_SUM_VALID pulses exactly once.
- Edge lengths:
  - I_LEN=0 -> no O_BUSY;
  - I_LEN=MAX_LEN+5 -> exactly MAX_LEN inputs accepted and MAX_LEN outputs produced;
  - I_START pulsed during EXP -> ignored.
- Saturation: len=2, I_X = 16'h7FFF, 16'h8000 -> the second d saturates, its O_E equals the exp-unit output at -2^15, and there is no wrap to a large value.
